// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access scheduler: FSM encoding, the
// register sweep table and the bus-controller address constants.
package rtc_pkg;

    // Number of RTC registers mirrored into the shadow file.
    localparam int N_REG = 9;

    // Control/status addresses owned by the low-level bus controller.
    localparam logic [7:0] DIR_CTRL_A = 8'd10;
    localparam logic [7:0] DIR_CTRL_B = 8'd11;

    // Sweep order: seconds, minutes, hours, day, month, year, timer h/m/s.
    // Entry 0 is the rightmost element.
    localparam logic [N_REG-1:0][7:0] TABLA_DIR = {
        8'd67, 8'd66, 8'd65,
        8'd38, 8'd37, 8'd36,
        8'd35, 8'd34, 8'd33
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_DONE_W = 3'd2,
        ST_RD     = 3'd3,
        ST_STORE  = 3'd4,
        ST_GAP    = 3'd5
    } estado_t;

    // Address of sweep slot idx; out-of-range indices fall back to slot 0.
    function automatic logic [7:0] dir_de_indice(input logic [3:0] idx);
        logic [7:0] dir;
        if (idx <= 4'(N_REG - 1)) begin
            dir = TABLA_DIR[idx];
        end else begin
            dir = TABLA_DIR[0];
        end
        return dir;
    endfunction

endpackage

// File: rtl/planificador_acceso_rtc_temporizador.sv
// Free-running refresh counter. Counts 0..REFRESH_CYC-1 and emits a
// one-cycle tick while holding the terminal value, i.e. once per period.
module temporizador_refresco_rtc #(
    parameter int unsigned REFRESH_CYC = 100000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam logic [23:0] ULTIMO = 24'(REFRESH_CYC - 1);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == ULTIMO) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/planificador_acceso_rtc.sv
// Scheduler for the RTC bus engine: periodic sweep of the nine time/timer
// registers into the shadow file, interleaved with configuration writes.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | transaction boundary; write has priority over a pending sweep
// WR       | actesc held, waiting for esclisto or timeout
// DONE_W   | wr_ack pulse (err on timeout)
// RD       | actlec held, waiting for memorialisto or timeout
// STORE    | snap_we pulse (or err on timeout), sweep index advanced
// GAP      | wait for both engine ready lines to drop before next access
module planificador_acceso_rtc
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYC = 100000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_req_i,
    input  logic [7:0] wr_dir_i,
    input  logic [7:0] wr_dato_i,
    output logic       wr_ack_o,
    output logic       err_o,
    output logic       busy_o,
    output logic       actesc_o,
    output logic       actlec_o,
    output logic [7:0] dirreg_o,
    output logic [7:0] datoreg_o,
    input  logic       esclisto_i,
    input  logic       memorialisto_i,
    input  logic [7:0] datomem_i,
    output logic       snap_we_o,
    output logic [3:0] snap_idx_o,
    output logic [7:0] snap_dato_o,
    output logic       sweep_done_o
);

    // Loaded on entry to WR/RD; act stays high for exactly TIMEOUT_CYC cycles
    // because the terminal compare happens on the edge after the count hits 0.
    localparam logic [7:0] TMO_INI = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] IDX_ULT = 4'(N_REG - 1);

    estado_t     estado_q;
    logic [7:0]  tmo_q;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic        pend_q;
    logic        tick;

    logic        wr_ack_q;
    logic        err_q;
    logic        busy_q;
    logic        actesc_q;
    logic        actlec_q;
    logic [7:0]  dirreg_q;
    logic [7:0]  datoreg_q;
    logic        snap_we_q;
    logic [3:0]  snap_idx_q;
    logic [7:0]  snap_dato_q;
    logic        sweep_done_q;

    temporizador_refresco_rtc #(
        .REFRESH_CYC(REFRESH_CYC)
    ) u_temporizador (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .tick_o (tick)
    );

    // Next sweep slot; the last slot wraps back to the first.
    always_comb begin
        idx_d = idx_q + 4'd1;
        if (idx_q == IDX_ULT) begin
            idx_d = '0;
        end
    end

    // Main sequencer: state, timeout counter, sweep bookkeeping and all
    // registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            estado_q     <= ST_IDLE;
            tmo_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            actesc_q     <= 1'b0;
            actlec_q     <= 1'b0;
            dirreg_q     <= '0;
            datoreg_q    <= '0;
            snap_we_q    <= 1'b0;
            snap_idx_q   <= '0;
            snap_dato_q  <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            wr_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            snap_we_q    <= 1'b0;
            sweep_done_q <= 1'b0;

            // A tick arriving while a sweep is still pending is simply lost.
            if (tick && !pend_q) begin
                pend_q <= 1'b1;
            end

            case (estado_q)
                ST_IDLE: begin
                    if (wr_req_i) begin
                        dirreg_q  <= wr_dir_i;
                        datoreg_q <= wr_dato_i;
                        actesc_q  <= 1'b1;
                        tmo_q     <= TMO_INI;
                        busy_q    <= 1'b1;
                        estado_q  <= ST_WR;
                    end else if (pend_q) begin
                        dirreg_q  <= dir_de_indice(idx_q);
                        actlec_q  <= 1'b1;
                        tmo_q     <= TMO_INI;
                        busy_q    <= 1'b1;
                        estado_q  <= ST_RD;
                    end
                end

                ST_WR: begin
                    if (esclisto_i || (tmo_q == '0)) begin
                        actesc_q <= 1'b0;
                        wr_ack_q <= 1'b1;
                        err_q    <= !esclisto_i;
                        estado_q <= ST_DONE_W;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end

                ST_DONE_W: begin
                    estado_q <= ST_GAP;
                end

                ST_RD: begin
                    if (memorialisto_i || (tmo_q == '0)) begin
                        actlec_q   <= 1'b0;
                        snap_we_q  <= memorialisto_i;
                        err_q      <= !memorialisto_i;
                        snap_idx_q <= idx_q;
                        if (memorialisto_i) begin
                            snap_dato_q <= datomem_i;
                        end
                        // A timed-out slot is skipped; the sweep still advances.
                        idx_q <= idx_d;
                        if (idx_q == IDX_ULT) begin
                            pend_q       <= 1'b0;
                            sweep_done_q <= 1'b1;
                        end
                        estado_q <= ST_STORE;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end

                ST_STORE: begin
                    estado_q <= ST_GAP;
                end

                ST_GAP: begin
                    if (!esclisto_i && !memorialisto_i) begin
                        busy_q   <= 1'b0;
                        estado_q <= ST_IDLE;
                    end
                end

                default: begin
                    actesc_q <= 1'b0;
                    actlec_q <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ack_o     = wr_ack_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign actesc_o     = actesc_q;
    assign actlec_o     = actlec_q;
    assign dirreg_o     = dirreg_q;
    assign datoreg_o    = datoreg_q;
    assign snap_we_o    = snap_we_q;
    assign snap_idx_o   = snap_idx_q;
    assign snap_dato_o  = snap_dato_q;
    assign sweep_done_o = sweep_done_q;

endmodule

// File: tb/tb_planificador_acceso_rtc.sv
// Bench for planificador_acceso_rtc: engine model with 2-cycle latency,
// expected transactions queued by the stimulus and checked by a monitor.
module tb_planificador_acceso_rtc;

    localparam int REF = 64;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_dir = '0;
    logic [7:0] wr_dato = '0;
    logic       esclisto = 1'b0;
    logic       memorialisto = 1'b0;
    logic [7:0] datomem = '0;

    logic       wr_ack, err, busy, actesc, actlec, snap_we, sweep_done;
    logic [7:0] dirreg, datoreg, snap_dato;
    logic [3:0] snap_idx;

    always #5 clk = ~clk;

    planificador_acceso_rtc #(
        .REFRESH_CYC(REF),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .wr_req_i      (wr_req),
        .wr_dir_i      (wr_dir),
        .wr_dato_i     (wr_dato),
        .wr_ack_o      (wr_ack),
        .err_o         (err),
        .busy_o        (busy),
        .actesc_o      (actesc),
        .actlec_o      (actlec),
        .dirreg_o      (dirreg),
        .datoreg_o     (datoreg),
        .esclisto_i    (esclisto),
        .memorialisto_i(memorialisto),
        .datomem_i     (datomem),
        .snap_we_o     (snap_we),
        .snap_idx_o    (snap_idx),
        .snap_dato_o   (snap_dato),
        .sweep_done_o  (sweep_done)
    );

    typedef struct packed {
        logic       kind;   // 1 = write ack, 0 = snap slot
        logic       we;
        logic       er;
        logic       done;
        logic [3:0] idx;
        logic [7:0] dir;
        logic [7:0] dato;
        logic [7:0] len;    // cycles the act line was held
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    logic       no_esc = 1'b0;
    logic [7:0] stuck_dir = 8'd0;
    logic [7:0] tbl [9] = '{8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd65, 8'd66, 8'd67};

    // Cycles since reset release; equals the refresh counter modulo REF.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] dat_of(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic push_rd(input int i, input bit tmo, input bit done);
        ev_t e;
        e.kind = 1'b0;
        e.we   = !tmo;
        e.er   = tmo;
        e.done = done;
        e.idx  = 4'(i);
        e.dir  = tbl[i];
        e.dato = tmo ? 8'd0 : dat_of(tbl[i]);
        e.len  = tmo ? 8'(TMO) : 8'd2;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] d, input logic [7:0] v, input bit tmo);
        ev_t e;
        e.kind = 1'b1;
        e.we   = 1'b0;
        e.er   = tmo;
        e.done = 1'b0;
        e.idx  = 4'd0;
        e.dir  = d;
        e.dato = v;
        e.len  = tmo ? 8'(TMO) : 8'd2;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int first, input int last, input int stuck);
        for (int i = first; i <= last; i++) push_rd(i, i == stuck, i == 8);
    endtask

    task automatic fail_to(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s got=timeout exp=event", nm);
    endtask

    task automatic wait_done(input int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (sweep_done) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("wait_sweep_done");
    endtask

    task automatic wait_rd(input logic [7:0] a, input int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (actlec && dirreg == a) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("wait_read_addr");
    endtask

    task automatic wait_ack(input int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (wr_ack) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("wait_wr_ack");
    endtask

    task automatic wait_idle(input int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("wait_idle");
    endtask

    task automatic wait_mod(input int m, input int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if ((cyc % REF) == m) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("wait_cycle_phase");
    endtask

    // Engine model: ready pulse two cycles after the command rises.
    initial begin
        int wcnt = 0;
        int rcnt = 0;
        forever begin
            @(negedge clk);
            if (esclisto) begin
                esclisto = 1'b0;
                wcnt = 0;
            end else if (actesc && !no_esc) begin
                wcnt++;
                if (wcnt == 2) esclisto = 1'b1;
            end else begin
                wcnt = 0;
            end
            if (memorialisto) begin
                memorialisto = 1'b0;
                rcnt = 0;
            end else if (actlec && dirreg != stuck_dir) begin
                rcnt++;
                if (rcnt == 2) begin
                    memorialisto = 1'b1;
                    datomem = dat_of(dirreg);
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor: every ack / snap slot is popped against the queue.
    initial begin
        int run = 0;
        int last = 0;
        ev_t g;
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
                last = 0;
            end else begin
                if (actesc || actlec) begin
                    run++;
                end else begin
                    if (run != 0) last = run;
                    run = 0;
                end
                if (wr_ack || snap_we || err || sweep_done) begin
                    g.kind = wr_ack;
                    g.we   = snap_we;
                    g.er   = err;
                    g.done = sweep_done;
                    g.idx  = wr_ack ? 4'd0 : snap_idx;
                    g.dir  = dirreg;
                    g.dato = wr_ack ? datoreg : (snap_we ? snap_dato : 8'd0);
                    g.len  = 8'(last);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event got=%h exp=none", g);
                    end else begin
                        e = exp_q.pop_front();
                        if (g !== e) begin
                            n_bad++;
                            $display("FAIL event kind=%0d idx=%0d got=%h exp=%h", e.kind, e.idx, g, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;

        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_ack, err, busy, actesc, actlec, dirreg, datoreg, snap_we, snap_idx, snap_dato, sweep_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got=%b/%b/%b/%h exp=all_zero", busy, actesc, actlec, dirreg);
        end
        reset = 1'b0;

        // No activity before the first refresh tick.
        quiet = 1'b1;
        for (int k = 0; k < REF - 1; k++) begin
            @(negedge clk);
            if (busy || actesc || actlec || snap_we || wr_ack) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL idle_quiet got=activity exp=none");
        end

        // Sweep 1: plain.
        push_sweep(0, 8, -1);
        wait_done(100);

        // Sweep 2: write requested while slot 3 is being read.
        push_sweep(0, 3, -1);
        push_wr(8'd34, 8'h59, 1'b0);
        push_sweep(4, 8, -1);
        wait_rd(8'd36, 200);
        wr_dir = 8'd34; wr_dato = 8'h59; wr_req = 1'b1;
        wait_ack(40);
        wr_req = 1'b0;
        wait_done(100);

        // Sweep 3: write request on the same edge as the refresh tick.
        push_wr(8'd65, 8'h07, 1'b0);
        push_sweep(0, 8, -1);
        wait_mod(REF - 1, 100);
        wr_dir = 8'd65; wr_dato = 8'h07; wr_req = 1'b1;
        wait_ack(20);
        wr_req = 1'b0;
        wait_done(100);

        // Write whose esclisto never comes, then sweep 4.
        no_esc = 1'b1;
        push_wr(8'd66, 8'hA5, 1'b1);
        push_sweep(0, 8, -1);
        wr_dir = 8'd66; wr_dato = 8'hA5; wr_req = 1'b1;
        wait_ack(40);
        wr_req = 1'b0;
        no_esc = 1'b0;
        wait_idle(10);
        wait_done(120);

        // Sweep 5: slot 5 never answers.
        stuck_dir = 8'd38;
        push_sweep(0, 8, 5);
        wait_done(150);
        stuck_dir = 8'd0;

        // Sweep 6: reset one cycle into the slot-2 read.
        push_sweep(0, 1, -1);
        wait_rd(8'd35, 200);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({wr_ack, err, busy, actesc, actlec, dirreg, datoreg, snap_we, snap_idx, snap_dato, sweep_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_rd got=%b/%b/%b/%h exp=all_zero", busy, actesc, actlec, dirreg);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL partial_sweep got=%0d pending exp=0", exp_q.size());
        end
        @(negedge clk);
        reset = 1'b0;

        // Sweep 7: restarts from slot 0 after the full refresh period.
        push_sweep(0, 8, -1);
        wait_done(150);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained got=%0d pending exp=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
